// File: rtl/irq_controller.sv
// irq_controller: edge-captured, maskable interrupt sources signalled to the
// processor over a four-phase ExtIRQ/ExtlAck handshake, lowest index first.
module irq_controller #(
    parameter int N = 64,
    parameter int NSRC = 4,
    parameter logic [N-1:0] MASK_ADDR = 'h100,
    parameter logic [N-1:0] CLR_ADDR = 'h108,
    localparam int IW = $clog2(NSRC)
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [N-1:0]    DM_addr,
    input  logic [N-1:0]    DM_writeData,
    input  logic            DM_writeEnable,
    input  logic            ExtlAck,
    output logic            ExtIRQ,
    output logic [IW-1:0]   irq_id,
    output logic [NSRC-1:0] irq_pending
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} stateT;
    stateT state;
    logic [NSRC-1:0] prevSrc, mask, active, clrStore, ackBits;
    logic [IW-1:0] lowestId;
    logic maskWr;
    logic unusedData;
    assign unusedData = ^DM_writeData[N-1:NSRC];
    assign active = irq_pending & mask;
    assign maskWr = DM_writeEnable && DM_addr == MASK_ADDR;
    assign clrStore = (DM_writeEnable && DM_addr == CLR_ADDR) ? DM_writeData[NSRC-1:0] : '0;
    always_comb begin
        lowestId = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (active[i]) lowestId = IW'(i);
        ackBits = '0;
        ackBits[irq_id] = state == REQ && ExtlAck;
    end
    // A fresh edge is OR-ed in after the clears so a simultaneous set wins.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ExtIRQ <= 1'b0;
            irq_id <= '0;
            irq_pending <= '0;
            prevSrc <= '0;
            mask <= '1;
        end else begin
            prevSrc <= irq_src;
            irq_pending <= (irq_pending & ~(clrStore | ackBits)) | (irq_src & ~prevSrc);
            if (maskWr) mask <= DM_writeData[NSRC-1:0];
            case (state)
                IDLE: if (|active) begin
                    irq_id <= lowestId;
                    ExtIRQ <= 1'b1;
                    state <= REQ;
                end
                REQ: if (ExtlAck) begin
                    ExtIRQ <= 1'b0;
                    state <= WAIT_REL;
                end
                WAIT_REL: if (!ExtlAck) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus random traffic against a
// behavioural model of the pending/mask/handshake rules.
module tb_irq_controller;
    logic CLOCK_50 = 1'b0;
    logic reset = 1'b0;
    logic [3:0] irq_src = '0;
    logic [63:0] DM_addr = '0, DM_writeData = '0;
    logic DM_writeEnable = 1'b0, ExtlAck = 1'b0;
    logic ExtIRQ;
    logic [1:0] irq_id;
    logic [3:0] irq_pending;
    int nCompared = 0, nMismatched = 0;
    logic [3:0] mPrev, mPend, mMask;
    logic mIrq, mWait;
    logic [1:0] mId;

    irq_controller dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .irq_src(irq_src),
        .DM_addr(DM_addr), .DM_writeData(DM_writeData), .DM_writeEnable(DM_writeEnable),
        .ExtlAck(ExtlAck), .ExtIRQ(ExtIRQ), .irq_id(irq_id), .irq_pending(irq_pending)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic modelReset();
        mPrev = '0; mPend = '0; mMask = 4'hF; mIrq = 1'b0; mWait = 1'b0; mId = '0;
    endtask

    task automatic modelStep();
        logic [3:0] clr;
        logic [3:0] rise;
        rise = irq_src & ~mPrev;
        clr = (DM_writeEnable && DM_addr == 64'h108) ? DM_writeData[3:0] : 4'h0;
        if (!mIrq && !mWait) begin
            if ((mPend & mMask) != 0) begin
                mIrq = 1'b1;
                mId = lowest(mPend & mMask);
            end
        end else if (mIrq) begin
            if (ExtlAck) begin
                clr[mId] = 1'b1;
                mIrq = 1'b0;
                mWait = 1'b1;
            end
        end else if (!ExtlAck) mWait = 1'b0;
        if (DM_writeEnable && DM_addr == 64'h100) mMask = DM_writeData[3:0];
        mPend = (mPend & ~clr) | rise;
        mPrev = irq_src;
    endtask

    task automatic compareAll();
        check("ExtIRQ", ExtIRQ, mIrq);
        check("irq_id", irq_id, mId);
        check("irq_pending", irq_pending, mPend);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            modelStep();
            #1 compareAll();
        end
    endtask

    task automatic store(input logic [63:0] addr, input logic [63:0] data);
        DM_addr = addr; DM_writeData = data; DM_writeEnable = 1'b1;
        tick(1);
        DM_writeEnable = 1'b0;
    endtask

    task automatic doReset();
        #1 reset = 1'b0;
        #1 modelReset();
        check("rst_ExtIRQ", ExtIRQ, 1'b0);
        check("rst_irq_id", irq_id, 2'd0);
        check("rst_pending", irq_pending, 4'h0);
        @(posedge CLOCK_50);
        #2 reset = 1'b1;
    endtask

    task automatic handshake();
        ExtlAck = 1'b1; tick(1);
        ExtlAck = 1'b0; tick(1);
    endtask

    initial begin
        modelReset();
        #2 compareAll();
        repeat (2) @(posedge CLOCK_50);
        #4 reset = 1'b1;
        tick(2);
        // single source: capture, request, acknowledge
        irq_src = 4'b0100; tick(1);
        check("s32_pend", irq_pending, 4'b0100);
        tick(1);
        check("s32_irq", ExtIRQ, 1'b1);
        check("s32_id", irq_id, 2'd2);
        ExtlAck = 1'b1; tick(1);
        check("s32_clr", irq_pending, 4'h0);
        check("s32_drop", ExtIRQ, 1'b0);
        ExtlAck = 1'b0; irq_src = 4'h0; tick(2);
        // two simultaneous edges served lowest first
        irq_src = 4'b1010; tick(2);
        check("s33_first", irq_id, 2'd1);
        handshake(); tick(1);
        check("s33_irq", ExtIRQ, 1'b1);
        check("s33_second", irq_id, 2'd3);
        handshake(); irq_src = 4'h0; tick(2);
        // masked source stays pending until unmasked
        store(64'h100, 64'h0);
        irq_src = 4'b0001; tick(1);
        check("s34_pend", irq_pending, 4'b0001);
        tick(2);
        check("s34_masked", ExtIRQ, 1'b0);
        store(64'h100, 64'h1); tick(1);
        check("s34_irq", ExtIRQ, 1'b1);
        check("s34_id", irq_id, 2'd0);
        handshake(); store(64'h100, 64'hF); irq_src = 4'h0; tick(2);
        // held acknowledge retires only one request
        irq_src = 4'b0011; tick(2);
        ExtlAck = 1'b1; tick(5);
        check("s35_pend", irq_pending, 4'b0010);
        check("s35_held", ExtIRQ, 1'b0);
        ExtlAck = 1'b0; tick(2);
        check("s35_irq", ExtIRQ, 1'b1);
        check("s35_id", irq_id, 2'd1);
        handshake(); irq_src = 4'h0; tick(2);
        // new edge coincident with acknowledge is kept and re-signalled
        irq_src = 4'b0100; tick(2);
        irq_src = 4'h0; tick(1);
        irq_src = 4'b0100; ExtlAck = 1'b1; tick(1);
        check("s37_pend", irq_pending, 4'b0100);
        ExtlAck = 1'b0; tick(2);
        check("s37_irq", ExtIRQ, 1'b1);
        check("s37_id", irq_id, 2'd2);
        handshake(); irq_src = 4'h0; tick(2);
        // async reset mid-request; source held high across release is captured
        store(64'h100, 64'h8);
        irq_src = 4'b1000; tick(2);
        check("s36_id", irq_id, 2'd3);
        doReset();
        tick(2);
        check("s36_recap", irq_pending, 4'b1000);
        check("s36_mask", ExtIRQ, 1'b1);
        handshake();
        for (int c = 0; c < 3000; c++) begin
            int k;
            irq_src ^= 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ExtlAck = ~ExtlAck;
            k = $urandom_range(0, 11);
            DM_writeEnable = k < 3;
            DM_addr = k == 0 ? 64'h100 : k == 1 ? 64'h108 : ($urandom_range(0, 1) ? 64'h110 : 64'h104);
            DM_writeData = {$urandom, $urandom};
            if ($urandom_range(0, 249) == 0) doReset();
            tick(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
